// File: rtl/ps2_packet_fsm_pkg.sv
// Shared types and constants for the PS/2 mouse 3-byte message framer.
package ps2_packet_fsm_pkg;

    localparam int unsigned PS2_BYTE_W   = 8;
    localparam int unsigned PS2_SYNC_BIT = 3;
    localparam logic [PS2_BYTE_W-1:0] PS2_SYNC_MASK = 8'(1 << PS2_SYNC_BIT);

    typedef enum logic [1:0] {
        BYTE1 = 2'b00,
        BYTE2 = 2'b01,
        BYTE3 = 2'b10,
        DONE  = 2'b11
    } ps2_state_e;

    // The first byte of every message carries the sync bit; all other bits are don't-care.
    function automatic logic is_sync_byte(input logic [PS2_BYTE_W-1:0] b);
        return ((b & PS2_SYNC_MASK) != 8'h00) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/ps2_packet_fsm.sv
// PS/2 mouse message framer: finds 3-byte message boundaries in a byte-per-cycle
// stream and pulses done for one cycle after the third byte is accepted.
module ps2_packet_fsm
    import ps2_packet_fsm_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PS2_BYTE_W-1:0] in_,
    output logic                  done
);

    ps2_state_e state_q;
    ps2_state_e state_d;
    logic       done_q;
    logic       done_d;
    logic       sync_s;

    assign sync_s = is_sync_byte(in_);

    // State and output register; done is registered alongside the state it decodes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BYTE1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; once a message starts it always consumes exactly three bytes.
    always_comb begin
        state_d = BYTE1;
        case (state_q)
            BYTE1: begin
                if (sync_s) begin
                    state_d = BYTE2;
                end else begin
                    state_d = BYTE1;
                end
            end
            BYTE2:   state_d = BYTE3;
            BYTE3:   state_d = DONE;
            DONE: begin
                if (sync_s) begin
                    state_d = BYTE2;
                end else begin
                    state_d = BYTE1;
                end
            end
            default: state_d = BYTE1;
        endcase
    end

    // Output decode of the upcoming state, so done_q equals (state_q == DONE).
    always_comb begin
        done_d = 1'b0;
        if (state_d == DONE) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_ps2_packet_fsm.sv
// Scoreboard bench for ps2_packet_fsm: directed vectors with hand-computed done values,
// then random bytes and reset pulses checked against a byte-count model.
module tb_ps2_packet_fsm;

    logic       clk;
    logic       reset;
    logic [7:0] in_;
    logic       done;

    int total;
    int bad;
    int m_cnt;
    int tag;
    logic exp_q[$];
    int   tag_q[$];

    ps2_packet_fsm dut (
        .clk   (clk),
        .reset (reset),
        .in_   (in_),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one byte for the coming rising edge and queue the done value expected after it.
    task automatic drive(input logic [7:0] b, input logic r, input logic e);
        @(negedge clk);
        in_   = b;
        reset = r;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tag = tag + 1;
    endtask

    // Golden model: count bytes of the current message; a finished message reopens the search.
    task automatic drive_model(input logic [7:0] b, input logic r);
        if (!r) begin
            m_cnt = 0;
        end else if (m_cnt == 0 || m_cnt == 3) begin
            m_cnt = b[3] ? 1 : 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        drive(b, r, (m_cnt == 3));
    endtask

    // Monitor: after each rising edge compare done against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic e;
            int   t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total = total + 1;
            if (done !== e) begin
                bad = bad + 1;
                $display("FAIL done step=%0d got=%b want=%b", t, done, e);
            end
        end
    end

    typedef struct {
        logic [7:0] b;
        logic       r;
        logic       e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        total = 0;
        bad   = 0;
        tag   = 0;
        m_cnt = 0;
        in_   = 8'h00;
        reset = 1'b0;

        vecs = '{
            // reset state
            '{8'h08, 1'b0, 1'b0}, '{8'h08, 1'b0, 1'b0},
            // basic message then a repeat
            '{8'h00, 1'b1, 1'b0}, '{8'h08, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b0},
            '{8'h00, 1'b1, 1'b1}, '{8'h00, 1'b1, 1'b0},
            '{8'h08, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b1},
            '{8'h00, 1'b1, 1'b0},
            // back-to-back: sync byte presented in the DONE cycle
            '{8'h08, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b1},
            '{8'h08, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b1},
            '{8'h00, 1'b1, 1'b0},
            // non-sync bits ignored; middle bytes take any value
            '{8'h25, 1'b1, 1'b0}, '{8'h52, 1'b1, 1'b0}, '{8'h38, 1'b1, 1'b0},
            '{8'hC8, 1'b1, 1'b0}, '{8'h32, 1'b1, 1'b1}, '{8'hF7, 1'b1, 1'b0},
            // continuous sync stream: period 3
            '{8'h08, 1'b1, 1'b0}, '{8'h08, 1'b1, 1'b0}, '{8'h08, 1'b1, 1'b1},
            '{8'h08, 1'b1, 1'b0}, '{8'h08, 1'b1, 1'b0}, '{8'h08, 1'b1, 1'b1},
            '{8'h08, 1'b1, 1'b0}, '{8'h08, 1'b1, 1'b0}, '{8'h08, 1'b1, 1'b1},
            '{8'h00, 1'b1, 1'b0},
            // mid-message reset discards the partial message
            '{8'h08, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b0},
            '{8'h08, 1'b0, 1'b0}, '{8'h08, 1'b0, 1'b0}, '{8'h08, 1'b0, 1'b0},
            '{8'h08, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b1},
            '{8'h00, 1'b1, 1'b0},
            // reset landing while in DONE clears done; sync in BYTE2 is not a resync
            '{8'hFF, 1'b1, 1'b0}, '{8'h08, 1'b1, 1'b0}, '{8'h08, 1'b1, 1'b1},
            '{8'h08, 1'b0, 1'b0}, '{8'h0F, 1'b1, 1'b0}, '{8'hF0, 1'b1, 1'b0},
            '{8'hF0, 1'b1, 1'b1}, '{8'hF7, 1'b1, 1'b0}
        };

        foreach (vecs[i]) begin
            drive(vecs[i].b, vecs[i].r, vecs[i].e);
        end

        // Random bytes and reset pulses against the model, starting from a reset.
        m_cnt = 0;
        drive_model(8'h00, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            logic       r;
            b = 8'($urandom_range(0, 255));
            r = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            drive_model(b, r);
        end

        // Drain the scoreboard with a bounded wait.
        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 20) begin
                @(negedge clk);
                budget = budget + 1;
            end
            if (exp_q.size() > 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL drain pending=%0d want=0", exp_q.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
